uart_tx: RTL and testbench

Serial 8N1 UART transmitter: the outbound partner of `uart_rx`. It drives the BLE module's `ble_uart_rx` pin from the 74.25 MHz pixel clock so the game can report state to the phone (score, state, acknowledgements). A small byte FIFO decouples gameplay-side writers from the serial bit rate. Bit timing matches `uart_rx` exactly, so both share one `BAUD_COUNT` value.

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the serial shifter.
// Define UART_TX_CTS_EN to gate frame starts on cts_n_in; otherwise cts_n_in is ignored.
module uart_tx #(
  parameter int BAUD_COUNT = 645,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          cts_n_in,
  output logic                          tx,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_COUNT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic cts_ok;
  logic push;
  logic pop;
  logic bit_done;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~cts_n_in;
`else
  logic unused_cts;
  assign unused_cts = cts_n_in;
  assign cts_ok     = 1'b1;
`endif

  // count_q excludes this cycle's push, so a byte pushed into an empty FIFO waits one edge.
  assign push     = valid_in && ready_q;
  assign pop      = (state_q == IDLE) && (count_q != '0) && cts_ok;
  assign bit_done = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (!push && pop) count_d = count_q - (PW + 1)'(1);
    ready_d = (count_d < DEPTH_C);
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d   = START;
          shift_d   = mem_q[rd_ptr_q];
          tx_d      = 1'b0;
          baud_d    = '0;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign tx        = tx_q;
  assign busy_out  = (state_q != IDLE);
  assign ready_out = ready_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_COUNT=4, FIFO_DEPTH=4; stimulus driven and outputs sampled on negedge.
// Flow-control tests follow UART_TX_CTS_EN so the bench matches the build under test.
module tb_uart_tx;
  localparam int BC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       cts_n_in;
  logic       tx;
  logic       busy_out;
  logic [2:0] count_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD_COUNT(BC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .cts_n_in(cts_n_in), .tx(tx),
    .busy_out(busy_out), .count_out(count_out)
  );

  // Waits for a start bit, then samples each bit in its second cycle; returns at the last STOP cycle.
  task automatic rx_byte(output logic [7:0] data, output logic frame_ok, output int waited,
                         output logic [2:0] cnt_seen, output logic timed_out);
    waited = 0; data = '0; frame_ok = 1'b0; cnt_seen = '0; timed_out = 1'b0;
    while (tx !== 1'b0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    cnt_seen = count_out;
    @(negedge clk);
    frame_ok = (tx === 1'b0) && (busy_out === 1'b1);
    for (int k = 0; k < 8; k++) begin
      repeat (BC) @(negedge clk);
      data[k] = tx;
    end
    repeat (BC) @(negedge clk);
    frame_ok = frame_ok && (tx === 1'b1);
    repeat (BC / 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; cts_n_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_out); else n_pass++;
    n_checks++; if (ready_out !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_out); else n_pass++;
    n_checks++; if (count_out !== 3'd0) $display("FAIL reset_count got %0d want 0", count_out); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    data_in = 8'hA5; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    n_checks++;
    if (tx !== 1'b1 || count_out !== 3'd1)
      $display("FAIL single_push tx=%b count=%0d want tx=1 count=1", tx, count_out);
    else n_pass++;
    for (int i = 1; i <= 10 * BC; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== frame[(i - 1) / BC] || busy_out !== 1'b1)
        $display("FAIL single_bit cycle %0d tx=%b busy=%b want tx=%b busy=1",
                 i, tx, busy_out, frame[(i - 1) / BC]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || busy_out !== 1'b0 || count_out !== 3'd0)
      $display("FAIL single_end tx=%b busy=%b count=%0d want 1/0/0", tx, busy_out, count_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [2:0] exp_cnt [3];
    logic [2:0] exp_start [3];
    bytes = '{8'h01, 8'h80, 8'hFF};
    exp_cnt = '{3'd1, 3'd1, 3'd2};
    exp_start = '{3'd1, 3'd1, 3'd0};
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          data_in = bytes[j]; valid_in = 1'b1;
          @(negedge clk);
          n_checks++;
          if (count_out !== exp_cnt[j])
            $display("FAIL burst_count push %0d got %0d want %0d", j, count_out, exp_cnt[j]);
          else n_pass++;
        end
        valid_in = 1'b0;
      end
      begin
        logic [7:0] d; logic ok; int w; logic [2:0] c; logic to;
        for (int j = 0; j < 3; j++) begin
          rx_byte(d, ok, w, c, to);
          n_checks++;
          if (to || !ok || d !== bytes[j])
            $display("FAIL burst_frame %0d got %h ok=%b to=%b want %h", j, d, ok, to, bytes[j]);
          else n_pass++;
          n_checks++;
          if (w != 2 || c !== exp_start[j])
            $display("FAIL burst_timing %0d gap=%0d count=%0d want gap=2 count=%0d",
                     j, w, c, exp_start[j]);
          else n_pass++;
        end
      end
    join
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_flow_control();
    logic [7:0] bytes [4];
    logic [2:0] exp_cnt [5];
    logic [4:0] exp_rdy;
    logic line_idle;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = 5'b00111;
    cts_n_in = 1'b1;
    for (int j = 0; j < 5; j++) begin
      data_in = (j == 4) ? 8'hxx : bytes[j]; valid_in = 1'b1;
      @(negedge clk);
      n_checks++;
      if (count_out !== exp_cnt[j] || ready_out !== exp_rdy[j] || tx !== 1'b1)
        $display("FAIL fill_push %0d count=%0d ready=%b tx=%b want %0d/%b/1",
                 j, count_out, ready_out, tx, exp_cnt[j], exp_rdy[j]);
      else n_pass++;
    end
    valid_in = 1'b0;
    line_idle = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_out !== 1'b0) line_idle = 1'b0;
    end
    n_checks++; if (!line_idle) $display("FAIL cts_hold line active got 0 want 1"); else n_pass++;
    cts_n_in = 1'b0;
    fork
      begin
        repeat (12) @(negedge clk);
        cts_n_in = 1'b1;
      end
      begin
        logic [7:0] d; logic ok; int w; logic [2:0] c; logic to;
        rx_byte(d, ok, w, c, to);
        n_checks++;
        if (to || !ok || d !== bytes[0] || w != 1)
          $display("FAIL cts_frame 0 got %h ok=%b gap=%0d want %h gap 1", d, ok, w, bytes[0]);
        else n_pass++;
        line_idle = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (tx !== 1'b1 || busy_out !== 1'b0) line_idle = 1'b0;
        end
        n_checks++;
        if (!line_idle || count_out !== 3'd3)
          $display("FAIL cts_midframe idle=%b count=%0d want 1/3", line_idle, count_out);
        else n_pass++;
        cts_n_in = 1'b0;
        for (int j = 1; j < 4; j++) begin
          rx_byte(d, ok, w, c, to);
          n_checks++;
          if (to || !ok || d !== bytes[j])
            $display("FAIL cts_frame %0d got %h ok=%b to=%b want %h", j, d, ok, to, bytes[j]);
          else n_pass++;
        end
      end
    join
  endtask
`else
  task automatic test_flow_control();
    logic [7:0] bytes [6];
    logic [2:0] exp_cnt [6];
    logic [5:0] exp_rdy;
    logic line_idle;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = 6'b001111;
    cts_n_in = 1'b1;
    fork
      begin
        for (int j = 0; j < 6; j++) begin
          data_in = (j == 5) ? 8'hxx : bytes[j]; valid_in = 1'b1;
          @(negedge clk);
          n_checks++;
          if (count_out !== exp_cnt[j] || ready_out !== exp_rdy[j])
            $display("FAIL fill_push %0d count=%0d ready=%b want %0d/%b",
                     j, count_out, ready_out, exp_cnt[j], exp_rdy[j]);
          else n_pass++;
        end
        valid_in = 1'b0;
      end
      begin
        logic [7:0] d; logic ok; int w; logic [2:0] c; logic to;
        for (int j = 0; j < 5; j++) begin
          rx_byte(d, ok, w, c, to);
          n_checks++;
          if (to || !ok || d !== bytes[j] || w != 2)
            $display("FAIL fill_frame %0d got %h ok=%b gap=%0d want %h gap 2", j, d, ok, w, bytes[j]);
          else n_pass++;
        end
      end
    join
    line_idle = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_out !== 1'b0) line_idle = 1'b0;
    end
    n_checks++;
    if (!line_idle || count_out !== 3'd0 || ready_out !== 1'b1)
      $display("FAIL fill_drain idle=%b count=%0d ready=%b want 1/0/1", line_idle, count_out, ready_out);
    else n_pass++;
    cts_n_in = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] bytes [3];
    logic line_idle;
    bytes = '{8'hF0, 8'h0F, 8'hAA};
    for (int j = 0; j < 3; j++) begin
      data_in = bytes[j]; valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    // Now 2 cycles into the START bit; cycle 18 of the frame lies inside data bit 3.
    repeat (16) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0 || busy_out !== 1'b1)
      $display("FAIL rst_mid_before tx=%b busy=%b want 0/1", tx, busy_out);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || count_out !== 3'd0 || busy_out !== 1'b0 || ready_out !== 1'b1)
      $display("FAIL rst_mid_after tx=%b count=%0d busy=%b ready=%b want 1/0/0/1",
               tx, count_out, busy_out, ready_out);
    else n_pass++;
    rst = 1'b0;
    line_idle = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_out !== 1'b0) line_idle = 1'b0;
    end
    n_checks++; if (!line_idle) $display("FAIL rst_mid_quiet activity got 1 want 0"); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_flow_control();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
